// File: rtl/convolution_core_if.sv
// Bus between the convolution AIP wrapper (memories, Csize, start/done) and the
// convolution datapath core.
interface convolution_core_if #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 5,
  parameter int ZADDRWIDTH = 6
);
  logic                  en_s;
  logic                  start;
  logic [9:0]            csize;
  logic [ADDRWIDTH-1:0]  x_addr;
  logic [DATAWIDTH-1:0]  x_data;
  logic [ADDRWIDTH-1:0]  y_addr;
  logic [DATAWIDTH-1:0]  y_data;
  logic [ZADDRWIDTH-1:0] z_addr;
  logic [DATAWIDTH-1:0]  z_data;
  logic                  z_we;
  logic                  busy;
  logic                  done;

  // Wrapper side: owns the memories and the Csize register.
  modport master (
    output en_s, start, csize, x_data, y_data,
    input  x_addr, y_addr, z_addr, z_data, z_we, busy, done
  );

  // Core side.
  modport slave (
    input  en_s, start, csize, x_data, y_data,
    output x_addr, y_addr, z_addr, z_data, z_we, busy, done
  );
endinterface

// File: rtl/convolution_core.sv
// Full linear convolution engine: Z[n] = sum_k X[k]*Y[n-k], one MAC per RD/MAC
// cycle pair, one MdataZ write per output sample, modulo 2^DATAWIDTH arithmetic.
module convolution_core #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 5,
  parameter int ZADDRWIDTH = 6
) (
  input logic               clk,
  input logic               rst_a,
  convolution_core_if.slave bus
);

  localparam int ZW = ZADDRWIDTH;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD,
    MAC,
    WR,
    FIN
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [4:0]            size_x;
  logic [4:0]            size_y;
  logic [ZW-1:0]         n;
  logic [ZW-1:0]         k;
  logic [ZW-1:0]         kmax;
  logic [ZW-1:0]         last_n;
  logic [DATAWIDTH-1:0]  acc;
  logic                  zero_size;

  // First X index contributing to Z[n]: max(0, n - sizeY + 1), evaluated without wrap.
  function automatic logic [ZW-1:0] k_lo(input logic [ZW-1:0] nn, input logic [4:0] sy);
    logic [ZW-1:0] np1;
    np1 = nn + ZW'(1);
    if (np1 > ZW'(sy))
      k_lo = np1 - ZW'(sy);
    else
      k_lo = '0;
  endfunction

  // Last X index contributing to Z[n]: min(n, sizeX - 1); sizeX is nonzero here.
  function automatic logic [ZW-1:0] k_hi(input logic [ZW-1:0] nn, input logic [4:0] sx);
    logic [ZW-1:0] top;
    top = ZW'(sx) - ZW'(1);
    if (nn < top)
      k_hi = nn;
    else
      k_hi = top;
  endfunction

  assign zero_size = (bus.csize[4:0] == 5'd0) || (bus.csize[9:5] == 5'd0);
  assign last_n    = ZW'(size_x) + ZW'(size_y) - ZW'(2);

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      state  <= IDLE;
      size_x <= '0;
      size_y <= '0;
      n      <= '0;
      k      <= '0;
      kmax   <= '0;
      acc    <= '0;
    end else if (bus.en_s) begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            size_x <= bus.csize[4:0];
            size_y <= bus.csize[9:5];
            n      <= '0;
          end
        end
        SETUP: begin
          acc  <= '0;
          k    <= k_lo(n, size_y);
          kmax <= k_hi(n, size_x);
        end
        MAC: begin
          // Product and sum both wrap at DATAWIDTH bits.
          acc <= acc + bus.x_data * bus.y_data;
          if (k != kmax)
            k <= k + ZW'(1);
        end
        WR: begin
          if (n != last_n)
            n <= n + ZW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start)
          state_nxt = zero_size ? FIN : SETUP;
      end
      SETUP: state_nxt = RD;
      RD:    state_nxt = MAC;
      MAC:   state_nxt = (k == kmax) ? WR : RD;
      WR:    state_nxt = (n == last_n) ? FIN : SETUP;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs; a frozen WR cycle must not repeat its write.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.z_we = 1'b0;
    case (state)
      SETUP, RD, MAC: bus.busy = 1'b1;
      WR: begin
        bus.busy = 1'b1;
        bus.z_we = bus.en_s;
      end
      FIN: bus.done = 1'b1;
      default: ;
    endcase
  end

  // Memories register the address, so the MAC cycle sees data for the RD address.
  assign bus.x_addr = ADDRWIDTH'(k);
  assign bus.y_addr = ADDRWIDTH'(n - k);
  assign bus.z_addr = n;
  assign bus.z_data = acc;

endmodule

// File: tb/tb_convolution_core.sv
// Directed bench for convolution_core: synchronous-read X/Y memories, a write
// monitor capturing MdataZ, and hand-computed expected samples and cycle numbers.
module tb_convolution_core;

  logic clk;
  logic rst_a;

  convolution_core_if #(.DATAWIDTH(32), .ADDRWIDTH(5), .ZADDRWIDTH(6)) bus ();

  convolution_core #(.DATAWIDTH(32), .ADDRWIDTH(5), .ZADDRWIDTH(6)) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .bus   (bus)
  );

  logic [31:0] xmem [0:31];
  logic [31:0] ymem [0:31];
  logic [31:0] zmem [0:63];

  int n_checks   = 0;
  int n_errors   = 0;
  int edge_cnt   = 0;
  int start_edge = 0;
  int wr_cnt     = 0;
  int order_err  = 0;
  int done_seen  = 0;
  int done_cyc   = -1;
  int last_wr    = -1;
  int busy_seen  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk) begin
    bus.x_data <= xmem[bus.x_addr];
    bus.y_data <= ymem[bus.y_addr];
  end

  function automatic int rel();
    return edge_cnt - start_edge + 1;
  endfunction

  always @(negedge clk) begin
    if (bus.z_we) begin
      zmem[bus.z_addr] = bus.z_data;
      if (int'(bus.z_addr) != wr_cnt) order_err++;
      wr_cnt++;
      last_wr = rel();
    end
    if (bus.done) begin
      done_seen++;
      done_cyc = rel();
    end
    if (bus.busy) busy_seen = 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 64; i++) zmem[i] = 32'hDEAD_BEEF;
    wr_cnt    = 0;
    order_err = 0;
    done_seen = 0;
    done_cyc  = -1;
    last_wr   = -1;
    busy_seen = 0;
  endtask

  task automatic launch(input logic [4:0] sx, input logic [4:0] sy);
    clear_log();
    @(negedge clk);
    bus.csize = {sy, sx};
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    start_edge = edge_cnt;
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (done_seen == 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    @(posedge clk);
    #1;
    check_val({tag, "_done_once"}, 64'(done_seen), 64'd1);
  endtask

  task automatic wait_rel(input int c);
    int i;
    i = 0;
    while (rel() != c && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    check_val("wait_rel", 64'(rel()), 64'(c));
  endtask

  task automatic load_5x5();
    logic [31:0] xv [0:4];
    logic [31:0] yv [0:4];
    xv = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd1};
    yv = '{32'd1, 32'd0, 32'd2, 32'd1, 32'd3};
    for (int i = 0; i < 5; i++) begin
      xmem[i] = xv[i];
      ymem[i] = yv[i];
    end
  endtask

  task automatic check_5x5(input string tag);
    logic [31:0] zv [0:8];
    zv = '{32'd1, 32'd2, 32'd5, 32'd9, 32'd12, 32'd17, 32'd15, 32'd13, 32'd3};
    for (int i = 0; i < 9; i++)
      check_val($sformatf("%s_z%0d", tag, i), 64'(zmem[i]), 64'(zv[i]));
    check_val({tag, "_wr_cnt"}, 64'(wr_cnt), 64'd9);
    check_val({tag, "_order"}, 64'(order_err), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      xmem[i] = '0;
      ymem[i] = '0;
    end
    clear_log();
    bus.en_s  = 1'b1;
    bus.start = 1'b1;
    bus.csize = {5'd5, 5'd5};
    rst_a     = 1'b0;

    // Reset held with start asserted
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy",   64'(bus.busy),   64'd0);
    check_val("rst_done",   64'(bus.done),   64'd0);
    check_val("rst_zwe",    64'(bus.z_we),   64'd0);
    check_val("rst_xaddr",  64'(bus.x_addr), 64'd0);
    check_val("rst_yaddr",  64'(bus.y_addr), 64'd0);
    check_val("rst_zaddr",  64'(bus.z_addr), 64'd0);
    check_val("rst_zdata",  64'(bus.z_data), 64'd0);
    bus.start = 1'b0;
    rst_a     = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_val("idle_busy_seen", 64'(busy_seen), 64'd0);
    check_val("idle_writes",    64'(wr_cnt),    64'd0);
    check_val("idle_done",      64'(done_seen), 64'd0);

    // Nominal 5x5
    load_5x5();
    launch(5'd5, 5'd5);
    wait_done("nom", 200);
    check_5x5("nom");
    check_val("nom_done_cyc", 64'(done_cyc), 64'd69);
    check_val("nom_last_wr",  64'(last_wr),  64'd68);

    // 1x1 minimal
    xmem[0] = 32'd7;
    ymem[0] = 32'd6;
    launch(5'd1, 5'd1);
    wait_done("min", 50);
    check_val("min_z0",       64'(zmem[0]),  64'd42);
    check_val("min_wr_cyc",   64'(last_wr),  64'd4);
    check_val("min_done_cyc", 64'(done_cyc), 64'd5);
    check_val("min_wr_cnt",   64'(wr_cnt),   64'd1);

    // 1x1 wrapping product
    xmem[0] = 32'hFFFF_FFFF;
    ymem[0] = 32'd2;
    launch(5'd1, 5'd1);
    wait_done("ovf", 50);
    check_val("ovf_z0", 64'(zmem[0]), 64'h0000_0000_FFFF_FFFE);

    // Degenerate sizeX = 0
    launch(5'd0, 5'd5);
    wait_done("deg", 50);
    repeat (5) @(posedge clk);
    #1;
    check_val("deg_done_cyc", 64'(done_cyc),  64'd1);
    check_val("deg_wr_cnt",   64'(wr_cnt),    64'd0);
    check_val("deg_busy",     64'(busy_seen), 64'd0);

    // Re-pulse start with a different csize mid-run
    load_5x5();
    launch(5'd5, 5'd5);
    wait_rel(20);
    bus.start = 1'b1;
    bus.csize = {5'd3, 5'd3};
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("rep", 200);
    check_5x5("rep");
    check_val("rep_done_cyc", 64'(done_cyc), 64'd69);

    // Enable dropped for 10 cycles starting in the n=3 write cycle
    launch(5'd5, 5'd5);
    wait_rel(28);
    bus.en_s = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.en_s = 1'b1;
    wait_done("ens", 200);
    check_5x5("ens");
    check_val("ens_done_cyc", 64'(done_cyc), 64'd79);

    // Abort by reset at cycle 30
    launch(5'd5, 5'd5);
    wait_rel(30);
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    check_val("abort_busy",  64'(bus.busy),   64'd0);
    check_val("abort_zaddr", 64'(bus.z_addr), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check_val("abort_wr_cnt", 64'(wr_cnt),    64'd4);
    check_val("abort_done",   64'(done_seen), 64'd0);

    // Asymmetric restart 3x2
    xmem[0] = 32'd1; xmem[1] = 32'd1; xmem[2] = 32'd1;
    ymem[0] = 32'd2; ymem[1] = 32'd3;
    launch(5'd3, 5'd2);
    wait_done("asy", 100);
    check_val("asy_z0", 64'(zmem[0]), 64'd2);
    check_val("asy_z1", 64'(zmem[1]), 64'd5);
    check_val("asy_z2", 64'(zmem[2]), 64'd5);
    check_val("asy_z3", 64'(zmem[3]), 64'd3);
    check_val("asy_wr_cnt",   64'(wr_cnt),   64'd4);
    check_val("asy_order",    64'(order_err), 64'd0);
    check_val("asy_done_cyc", 64'(done_cyc), 64'd21);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
